mem_arb2: RTL and testbench

Two-port arbiter that shares one single-port synchronous-read byte memory (mem_1024x8b / mem_512x8b class) between two requesters, e.g. the UART command path and a background fill/scan engine. Each cycle it grants at most one request using round-robin priority, drives the memory port from the winner and returns read data one cycle later with a per-requester valid strobe. A lock mechanism lets one requester own the memory for a multi-access burst.

---
 rtl/mem_arb2.sv | 123 ++++++++++++
 tb/tb_mem_arb2.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb2.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb2
// Description : Round-robin arbiter sharing one synchronous-read memory port
//               between two requesters, with per-requester burst lock.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb2 #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic              i_lock0,
    input  logic              i_lock1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    output logic [DATA_W-1:0] o_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_locked
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOCK0 = 2'd1;
    localparam logic [1:0] c_LOCK1 = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_last;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic              w_gnt0;
    logic              w_gnt1;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_mem_wdata;

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state   <= c_IDLE;
            r_last    <= 1'b1;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rvalid0 <= w_gnt0 & ~i_we0;
            r_rvalid1 <= w_gnt1 & ~i_we1;
            if (w_gnt0) begin
                r_last <= 1'b0;
            end else if (w_gnt1) begin
                r_last <= 1'b1;
            end
        end
    end

    // Grant and lock transitions; nothing is granted while reset is held.
    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = ((r_state == c_LOCK0) || (r_state == c_LOCK1)) ? r_state : c_IDLE;
        if (i_nrst) begin
            case (r_state)
                c_LOCK0: w_gnt0 = i_req0;
                c_LOCK1: w_gnt1 = i_req1;
                default: begin
                    if (i_req0 && i_req1) begin
                        w_gnt0 = r_last;
                        w_gnt1 = ~r_last;
                    end else begin
                        w_gnt0 = i_req0;
                        w_gnt1 = i_req1;
                    end
                end
            endcase
            if (w_gnt0) begin
                w_state_nxt = i_lock0 ? c_LOCK0 : c_IDLE;
            end else if (w_gnt1) begin
                w_state_nxt = i_lock1 ? c_LOCK1 : c_IDLE;
            end
        end
    end

    always_comb begin
        w_mem_addr  = '0;
        w_mem_we    = 1'b0;
        w_mem_wdata = '0;
        if (w_gnt0) begin
            w_mem_addr  = i_addr0;
            w_mem_we    = i_we0;
            w_mem_wdata = i_wdata0;
        end else if (w_gnt1) begin
            w_mem_addr  = i_addr1;
            w_mem_we    = i_we1;
            w_mem_wdata = i_wdata1;
        end
    end

    assign o_gnt0      = w_gnt0;
    assign o_gnt1      = w_gnt1;
    // A reset arriving with a read in flight hides the pending strobe at once.
    assign o_rvalid0   = r_rvalid0 & i_nrst;
    assign o_rvalid1   = r_rvalid1 & i_nrst;
    assign o_rdata     = i_mem_rdata;
    assign o_mem_addr  = w_mem_addr;
    assign o_mem_we    = w_mem_we;
    assign o_mem_wdata = w_mem_wdata;
    assign o_locked    = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arb2.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arb2
// Description : Scoreboard testbench for mem_arb2 with behavioural memories.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arb2;

    logic       clk;
    logic       nrst;
    int         checks;
    int         failures;

    logic       req0, req1, we0, we1, lock0, lock1;
    logic [9:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rv0, rv1, mem_we, locked;
    logic [7:0] rdata, mem_wdata, mem_rdata;
    logic [9:0] mem_addr;

    logic       b_req0, b_req1, b_we0, b_we1, b_lock0, b_lock1;
    logic [8:0] b_addr0, b_addr1;
    logic [7:0] b_wdata0, b_wdata1;
    logic       b_gnt0, b_gnt1, b_rv0, b_rv1, b_mem_we, b_locked;
    logic [7:0] b_rdata, b_mem_wdata, b_mem_rdata;
    logic [8:0] b_mem_addr;

    logic [7:0] mem_a [1024];
    logic [7:0] mem_b [512];
    logic [7:0] shadow [1024];

    typedef struct {
        logic       port;
        logic [7:0] data;
    } exp_t;
    exp_t sbq[$];

    mem_arb2 #(.ADDR_W(10), .DATA_W(8)) dut (
        .i_clk(clk), .i_nrst(nrst),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_lock0(lock0), .i_lock1(lock1), .i_addr0(addr0), .i_addr1(addr1),
        .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rv0), .o_rvalid1(rv1),
        .o_rdata(rdata), .o_mem_addr(mem_addr), .o_mem_we(mem_we),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_locked(locked)
    );

    mem_arb2 #(.ADDR_W(9), .DATA_W(8)) dut_w9 (
        .i_clk(clk), .i_nrst(nrst),
        .i_req0(b_req0), .i_req1(b_req1), .i_we0(b_we0), .i_we1(b_we1),
        .i_lock0(b_lock0), .i_lock1(b_lock1), .i_addr0(b_addr0), .i_addr1(b_addr1),
        .i_wdata0(b_wdata0), .i_wdata1(b_wdata1),
        .o_gnt0(b_gnt0), .o_gnt1(b_gnt1), .o_rvalid0(b_rv0), .o_rvalid1(b_rv1),
        .o_rdata(b_rdata), .o_mem_addr(b_mem_addr), .o_mem_we(b_mem_we),
        .o_mem_wdata(b_mem_wdata), .i_mem_rdata(b_mem_rdata), .o_locked(b_locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem_a[mem_addr] <= mem_wdata;
        mem_rdata <= mem_a[mem_addr];
        if (b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
        b_mem_rdata <= mem_b[b_mem_addr];
    end

    // Every read strobe must match the oldest expected read in the scoreboard.
    always @(negedge clk) begin
        if (rv0 || rv1) begin
            exp_t e;
            checks++;
            if (rv0 && rv1) begin
                failures++;
                $display("FAIL rvalid_exclusive: rvalid0=%0b rvalid1=%0b, want not both", rv0, rv1);
            end else if (sbq.size() == 0) begin
                failures++;
                $display("FAIL rvalid_unexpected: rvalid0=%0b rvalid1=%0b, want none", rv0, rv1);
            end else begin
                e = sbq.pop_front();
                if (rv1 !== e.port || rdata !== e.data) begin
                    failures++;
                    $display("FAIL rdata_scoreboard: port=%0d data=%02h, want port=%0d data=%02h",
                             rv1, rdata, e.port, e.data);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic do_reset;
        nrst = 1'b0;
        tick();
        tick();
        nrst = 1'b1;
    endtask

    task automatic test_reset;
        nrst = 1'b0;
        req0 = 1; req1 = 1; we0 = 1; we1 = 1; addr0 = 10'h3FF; wdata0 = 8'hFF;
        tick();
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_forced: gnt0=%0b gnt1=%0b mem_we=%0b, want 0 0 0", gnt0, gnt1, mem_we);
        end
        checks++;
        if (locked !== 1'b0 || rv0 !== 1'b0 || rv1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: locked=%0b rv0=%0b rv1=%0b, want 0 0 0", locked, rv0, rv1);
        end
        tick();
        idle_inputs();
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_write_read;
        req0 = 1; we0 = 1; addr0 = 10'h155; wdata0 = 8'hA5;
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 10'h155 || mem_wdata !== 8'hA5) begin
            failures++;
            $display("FAIL wr_grant: gnt0=%0b gnt1=%0b we=%0b addr=%03h wdata=%02h, want 1 0 1 155 a5",
                     gnt0, gnt1, mem_we, mem_addr, mem_wdata);
        end
        shadow[10'h155] = 8'hA5;
        tick();
        we0 = 0;
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h155) begin
            failures++;
            $display("FAIL rd_grant: gnt0=%0b we=%0b addr=%03h, want 1 0 155", gnt0, mem_we, mem_addr);
        end
        sbq.push_back('{port: 1'b0, data: shadow[10'h155]});
        tick();
        idle_inputs();
        tick();
        tick();
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL wr_rd_drain: pending=%0d, want 0", sbq.size());
        end
    endtask

    task automatic test_contention;
        do_reset();
        req0 = 1; req1 = 1; addr0 = 10'h001; addr1 = 10'h002;
        for (int i = 0; i < 4; i++) begin
            logic       w;
            logic [9:0] a;
            w = logic'(i % 2);
            a = w ? 10'h002 : 10'h001;
            @(negedge clk);
            checks++;
            if (gnt0 !== ~w || gnt1 !== w || mem_addr !== a) begin
                failures++;
                $display("FAIL contention_%0d: gnt0=%0b gnt1=%0b addr=%03h, want %0b %0b %03h",
                         i, gnt0, gnt1, mem_addr, ~w, w, a);
            end
            sbq.push_back('{port: w, data: shadow[a]});
            tick();
        end
        idle_inputs();
        tick();
        tick();
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL contention_drain: pending=%0d, want 0", sbq.size());
        end
    endtask

    task automatic test_lock;
        addr0 = 10'h010;
        // Step 2 has req1 parked to show the lock survives an idle owner.
        for (int i = 0; i < 5; i++) begin
            int n;
            n = (i > 2) ? i - 1 : i;
            req0  = (i > 0);
            req1  = (i != 2);
            we1   = 1;
            lock1 = (n < 3);
            addr1 = 10'h020 + 10'(n);
            wdata1 = 8'hC0 + 8'(n);
            @(negedge clk);
            checks++;
            if (gnt0 !== 1'b0 || gnt1 !== (i != 2) || (i > 0 && locked !== 1'b1)) begin
                failures++;
                $display("FAIL lock_step_%0d: gnt0=%0b gnt1=%0b locked=%0b, want 0 %0b 1",
                         i, gnt0, gnt1, locked, (i != 2));
            end
            if (i != 2) shadow[10'h020 + 10'(n)] = 8'hC0 + 8'(n);
            tick();
        end
        req1 = 0; we1 = 0; lock1 = 0;
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1 || locked !== 1'b0 || mem_addr !== 10'h010) begin
            failures++;
            $display("FAIL lock_release: gnt0=%0b locked=%0b addr=%03h, want 1 0 010", gnt0, locked, mem_addr);
        end
        sbq.push_back('{port: 1'b0, data: shadow[10'h010]});
        tick();
        idle_inputs();
        req1 = 1; addr1 = 10'h022;
        @(negedge clk);
        checks++;
        if (gnt1 !== 1'b1) begin
            failures++;
            $display("FAIL lock_readback_gnt: gnt1=%0b, want 1", gnt1);
        end
        sbq.push_back('{port: 1'b1, data: shadow[10'h022]});
        tick();
        idle_inputs();
        tick();
        tick();
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL lock_drain: pending=%0d, want 0", sbq.size());
        end
    endtask

    task automatic test_idle;
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (mem_we !== 1'b0 || mem_addr !== 10'h000 || mem_wdata !== 8'h00 ||
                gnt0 !== 1'b0 || gnt1 !== 1'b0 || rv0 !== 1'b0 || rv1 !== 1'b0) begin
                failures++;
                $display("FAIL idle_%0d: we=%0b addr=%03h wd=%02h gnt=%0b%0b rv=%0b%0b, want all 0",
                         i, mem_we, mem_addr, mem_wdata, gnt0, gnt1, rv0, rv1);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_lock;
        req0 = 1; we0 = 0; lock0 = 1; addr0 = 10'h155;
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1) begin
            failures++;
            $display("FAIL midlock_take: gnt0=%0b, want 1", gnt0);
        end
        tick();
        idle_inputs();
        nrst = 1'b0;
        @(negedge clk);
        checks++;
        if (rv0 !== 1'b0) begin
            failures++;
            $display("FAIL midlock_rvalid: rvalid0=%0b, want 0", rv0);
        end
        tick();
        nrst = 1'b1;
        req1 = 1; addr1 = 10'h002;
        @(negedge clk);
        checks++;
        if (locked !== 1'b0 || gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            failures++;
            $display("FAIL midlock_after: locked=%0b gnt1=%0b gnt0=%0b, want 0 1 0", locked, gnt1, gnt0);
        end
        sbq.push_back('{port: 1'b1, data: shadow[10'h002]});
        tick();
        idle_inputs();
        tick();
        tick();
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL midlock_drain: pending=%0d, want 0", sbq.size());
        end
    endtask

    task automatic test_width;
        b_req0 = 1; b_we0 = 1; b_addr0 = 9'h1FF; b_wdata0 = 8'h3C;
        @(negedge clk);
        checks++;
        if (b_gnt0 !== 1'b1 || b_mem_we !== 1'b1 || b_mem_addr !== 9'h1FF || b_mem_wdata !== 8'h3C) begin
            failures++;
            $display("FAIL w9_write: gnt0=%0b we=%0b addr=%03h wd=%02h, want 1 1 1ff 3c",
                     b_gnt0, b_mem_we, b_mem_addr, b_mem_wdata);
        end
        tick();
        b_we0 = 0;
        @(negedge clk);
        checks++;
        if (b_gnt0 !== 1'b1 || b_mem_we !== 1'b0 || b_rv0 !== 1'b0) begin
            failures++;
            $display("FAIL w9_read_gnt: gnt0=%0b we=%0b rv0=%0b, want 1 0 0", b_gnt0, b_mem_we, b_rv0);
        end
        tick();
        b_req0 = 0;
        @(negedge clk);
        checks++;
        if (b_rv0 !== 1'b1 || b_rv1 !== 1'b0 || b_rdata !== 8'h3C) begin
            failures++;
            $display("FAIL w9_rdata: rv0=%0b rv1=%0b rdata=%02h, want 1 0 3c", b_rv0, b_rv1, b_rdata);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i]  = 8'(i) ^ 8'h5A;
            shadow[i] = 8'(i) ^ 8'h5A;
        end
        for (int i = 0; i < 512; i++) mem_b[i] = 8'h00;
        idle_inputs();
        b_req0 = 0; b_req1 = 0; b_we0 = 0; b_we1 = 0; b_lock0 = 0; b_lock1 = 0;
        b_addr0 = '0; b_addr1 = '0; b_wdata0 = '0; b_wdata1 = '0;
        nrst = 1'b0;
        #1;
        test_reset();
        test_write_read();
        test_contention();
        test_lock();
        test_idle();
        test_reset_mid_lock();
        test_width();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
